// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller and the trap logic
// that consumes its irq/irq_id outputs.
package irq_ctrl_pkg;

    localparam int MAX_IRQ      = 31;
    localparam int MAX_ID_WIDTH = 5;

    typedef logic [MAX_ID_WIDTH-1:0] irq_id_t;

    localparam irq_id_t     IRQ_NONE  = '0;
    localparam logic [31:0] TRAP_ADDR = 32'h0000_0100;

    typedef enum logic {
        TRIG_LEVEL = 1'b0,
        TRIG_EDGE  = 1'b1
    } trig_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// Handshake between the interrupt controller (slave) and the cpu trap logic
// (master): request/id out, claim/complete back.
interface irq_ctrl_if #(
    parameter int ID_WIDTH = 4
);

    logic                irq;
    logic [ID_WIDTH-1:0] irq_id;
    logic                claim;
    logic                complete;
    logic [ID_WIDTH-1:0] complete_id;

    modport master (
        input  irq,
        input  irq_id,
        output claim,
        output complete,
        output complete_id
    );

    modport slave (
        output irq,
        output irq_id,
        input  claim,
        input  complete,
        input  complete_id
    );

endinterface

// File: rtl/irq_sync.sv
// Synchroniser for one asynchronous interrupt source, with an optional
// rising-edge detector for edge-triggered sources.
module irq_sync
    import irq_ctrl_pkg::*;
#(
    parameter int    SYNC_STAGES = 2,
    parameter trig_e TRIGGER     = TRIG_LEVEL
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic event_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (TRIGGER == TRIG_EDGE) begin : g_edge
            logic s_d;
            logic rise_q;

            // The rise pulse is registered, so edge sources lag level ones by a cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s_d    <= 1'b0;
                    rise_q <= 1'b0;
                end else begin
                    s_d    <= s;
                    rise_q <= s & ~s_d;
                end
            end

            assign event_out = rise_q;
        end else begin : g_level
            assign event_out = s;
        end
    endgenerate

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronised edge/level sources, enable/pending/active
// tracking and a fixed lowest-index-wins priority encoder feeding the trap logic.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int                 NUM_IRQ     = 8,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
    parameter bit                 NESTED      = 1'b0,
    parameter int                 ID_WIDTH    = $clog2(NUM_IRQ + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] src,
    input  logic               en_we,
    input  logic [NUM_IRQ-1:0] en_data,
    irq_ctrl_if.slave          trap,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] active
);

    logic [NUM_IRQ-1:0]  src_evt;
    logic [NUM_IRQ-1:0]  enable_q;
    logic [NUM_IRQ-1:0]  pending_q;
    logic [NUM_IRQ-1:0]  active_q;
    logic                irq_q;
    logic [ID_WIDTH-1:0] irq_id_q;

    logic [NUM_IRQ-1:0]  claim_vec;
    logic [NUM_IRQ-1:0]  complete_vec;
    logic [NUM_IRQ-1:0]  pending_nxt;
    logic [NUM_IRQ-1:0]  active_nxt;
    logic [NUM_IRQ-1:0]  enable_nxt;
    logic [NUM_IRQ-1:0]  eligible;
    logic                irq_nxt;
    logic [ID_WIDTH-1:0] irq_id_nxt;

    generate
        for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
            irq_sync #(
                .SYNC_STAGES (SYNC_STAGES),
                .TRIGGER     (trig_e'(EDGE_MASK[i]))
            ) u_sync (
                .clk       (clk),
                .rst       (rst),
                .src       (src[i]),
                .event_out (src_evt[i])
            );
        end
    endgenerate

    // Irq/irq_id are computed from the post-update state so a claimed or
    // disabled source disappears from irq on the very next cycle.
    always_comb begin
        claim_vec    = '0;
        complete_vec = '0;
        pending_nxt  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (trap.claim && irq_q && irq_id_q == ID_WIDTH'(i + 1)) begin
                claim_vec[i] = 1'b1;
            end
            if (trap.complete && trap.complete_id == ID_WIDTH'(i + 1) && active_q[i]) begin
                complete_vec[i] = 1'b1;
            end
        end

        // Claim is applied after complete so it wins when both name one source.
        active_nxt = (active_q & ~complete_vec) | claim_vec;
        enable_nxt = en_we ? en_data : enable_q;

        for (int i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MASK[i]) begin
                pending_nxt[i] = (pending_q[i] & ~claim_vec[i]) | src_evt[i];
            end else begin
                pending_nxt[i] = src_evt[i] & ~active_q[i] & ~claim_vec[i];
            end
        end

        eligible = pending_nxt & enable_nxt & ~active_nxt;
        if (!NESTED && (|active_nxt)) begin
            eligible = '0;
        end

        irq_nxt    = |eligible;
        irq_id_nxt = ID_WIDTH'(IRQ_NONE);
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                irq_id_nxt = ID_WIDTH'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q  <= '0;
            pending_q <= '0;
            active_q  <= '0;
            irq_q     <= 1'b0;
            irq_id_q  <= ID_WIDTH'(IRQ_NONE);
        end else begin
            enable_q  <= enable_nxt;
            pending_q <= pending_nxt;
            active_q  <= active_nxt;
            irq_q     <= irq_nxt;
            irq_id_q  <= irq_id_nxt;
        end
    end

    assign trap.irq    = irq_q;
    assign trap.irq_id = irq_id_q;
    assign pending     = pending_q;
    assign active      = active_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: two instances (NESTED=0 and NESTED=1) share sources and
// enables, each compared every cycle against a rule-level reference model.
module tb_irq_ctrl;

    localparam int          NI   = 8;
    localparam int          S    = 2;
    localparam logic [7:0]  EDGE = 8'h82;

    typedef struct packed {
        logic       rst;
        logic [7:0] src;
        logic       en_we;
        logic [7:0] en_data;
        logic [1:0] claim;
        logic [1:0] complete;
        logic [3:0] cid;
    } step_t;

    logic       clk;
    logic       rst_r;
    logic [7:0] src_r;
    logic       en_we_r;
    logic [7:0] en_data_r;
    logic [1:0] claim_r;
    logic [1:0] complete_r;
    logic [3:0] cid_r [2];

    logic [7:0] pend0, act0, pend1, act1;
    logic       obs_irq  [2];
    logic [3:0] obs_id   [2];
    logic [7:0] obs_pend [2];
    logic [7:0] obs_act  [2];

    logic [7:0] hist [S+3];
    logic [7:0] m_pend [2];
    logic [7:0] m_act  [2];
    logic [7:0] m_en   [2];
    logic       m_irq  [2];
    logic [3:0] m_id   [2];

    int n_vec;
    int n_err;

    irq_ctrl_if #(.ID_WIDTH(4)) bus0 ();
    irq_ctrl_if #(.ID_WIDTH(4)) bus1 ();

    assign bus0.claim       = claim_r[0];
    assign bus0.complete    = complete_r[0];
    assign bus0.complete_id = cid_r[0];
    assign bus1.claim       = claim_r[1];
    assign bus1.complete    = complete_r[1];
    assign bus1.complete_id = cid_r[1];

    assign obs_irq[0]  = bus0.irq;
    assign obs_id[0]   = bus0.irq_id;
    assign obs_pend[0] = pend0;
    assign obs_act[0]  = act0;
    assign obs_irq[1]  = bus1.irq;
    assign obs_id[1]   = bus1.irq_id;
    assign obs_pend[1] = pend1;
    assign obs_act[1]  = act1;

    irq_ctrl #(
        .NUM_IRQ(NI), .SYNC_STAGES(S), .EDGE_MASK(EDGE), .NESTED(1'b0), .ID_WIDTH(4)
    ) dut0 (
        .clk(clk), .rst(rst_r), .src(src_r), .en_we(en_we_r), .en_data(en_data_r),
        .trap(bus0), .pending(pend0), .active(act0)
    );

    irq_ctrl #(
        .NUM_IRQ(NI), .SYNC_STAGES(S), .EDGE_MASK(EDGE), .NESTED(1'b1), .ID_WIDTH(4)
    ) dut1 (
        .clk(clk), .rst(rst_r), .src(src_r), .en_we(en_we_r), .en_data(en_data_r),
        .trap(bus1), .pending(pend1), .active(act1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sources seen through an S-edge delay line; edge events take one
    // extra edge; then the pending/active/enable rules and lowest-index priority.
    task automatic model_step();
        logic [7:0] lvl, rise, na, np, ne;
        int claimed, c;
        if (rst_r) begin
            foreach (hist[j]) hist[j] = '0;
            for (int d = 0; d < 2; d++) begin
                m_pend[d] = '0; m_act[d] = '0; m_en[d] = '0; m_irq[d] = 1'b0; m_id[d] = '0;
            end
            return;
        end
        for (int j = S + 2; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = src_r;
        lvl  = hist[S];
        rise = hist[S+1] & ~hist[S+2];
        for (int d = 0; d < 2; d++) begin
            claimed = -1;
            if (claim_r[d] && m_irq[d]) claimed = int'(m_id[d]) - 1;
            c  = int'(cid_r[d]);
            na = m_act[d];
            if (complete_r[d] && c >= 1 && c <= NI && m_act[d][c-1]) na[c-1] = 1'b0;
            if (claimed >= 0) na[claimed] = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (EDGE[i]) np[i] = (m_pend[d][i] && i != claimed) || rise[i];
                else         np[i] = lvl[i] && !m_act[d][i] && i != claimed;
            end
            ne = en_we_r ? en_data_r : m_en[d];
            m_irq[d] = 1'b0;
            m_id[d]  = '0;
            if (d == 1 || na == 8'h00) begin
                for (int i = 0; i < NI && !m_irq[d]; i++) begin
                    if (np[i] && ne[i] && !na[i]) begin
                        m_irq[d] = 1'b1;
                        m_id[d]  = 4'(i + 1);
                    end
                end
            end
            m_pend[d] = np;
            m_act[d]  = na;
            m_en[d]   = ne;
        end
    endtask

    task automatic clock_edge();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input step_t st);
        rst_r      = st.rst;
        src_r      = st.src;
        en_we_r    = st.en_we;
        en_data_r  = st.en_data;
        claim_r    = st.claim;
        complete_r = st.complete;
        cid_r[0]   = st.cid;
        cid_r[1]   = st.cid;
    endtask

    function automatic step_t mk(input logic r, input logic [7:0] s, input logic we,
                                 input logic [7:0] ed, input logic [1:0] cl,
                                 input logic [1:0] cp, input logic [3:0] id);
        step_t st;
        st.rst = r; st.src = s; st.en_we = we; st.en_data = ed;
        st.claim = cl; st.complete = cp; st.cid = id;
        return st;
    endfunction

    task automatic reset_dut();
        apply_stimulus(mk(1'b1, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 4'd0));
        clock_edge();
        apply_stimulus(mk(1'b0, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 4'd0));
    endtask

    task automatic test_reset();
        apply_stimulus(mk(1'b1, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 4'd0));
        clock_edge();
        clock_edge();
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (obs_irq[d] !== 1'b0 || obs_id[d] !== 4'd0 || obs_pend[d] !== 8'h00 || obs_act[d] !== 8'h00) begin
                n_err++;
                $display("[TB] FAIL reset dut%0d: got irq=%0b id=%0d pend=%h act=%h, expected all zero",
                         d, obs_irq[d], obs_id[d], obs_pend[d], obs_act[d]);
            end
        end
        apply_stimulus(mk(1'b0, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00, 4'd0));
    endtask

    task automatic test_level_claim();
        step_t seq[$];
        reset_dut();
        seq.push_back(mk(0, 8'h00, 1, 8'hFF, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h08, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h08, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h08, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h08, 0, 8'h00, 2'b11, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h08, 0, 8'h00, 2'b00, 2'b11, 4'd4));
        seq.push_back(mk(0, 8'h08, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h00, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        foreach (seq[k]) begin
            apply_stimulus(seq[k]);
            clock_edge();
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if ({obs_irq[d], obs_id[d], obs_pend[d], obs_act[d]} !== {m_irq[d], m_id[d], m_pend[d], m_act[d]}) begin
                    n_err++;
                    $display("[TB] FAIL level_claim step %0d dut%0d: got irq=%0b id=%0d pend=%h act=%h, expected irq=%0b id=%0d pend=%h act=%h",
                             k, d, obs_irq[d], obs_id[d], obs_pend[d], obs_act[d], m_irq[d], m_id[d], m_pend[d], m_act[d]);
                end
                if (k == 2 || k == 3 || k == 4 || k == 6) begin
                    n_vec++;
                    if ((k == 2 && obs_irq[d] !== 1'b0) ||
                        (k == 3 && (obs_irq[d] !== 1'b1 || obs_id[d] !== 4'd4)) ||
                        (k == 4 && (obs_irq[d] !== 1'b0 || obs_act[d] !== 8'h08)) ||
                        (k == 6 && (obs_irq[d] !== 1'b1 || obs_id[d] !== 4'd4))) begin
                        n_err++;
                        $display("[TB] FAIL level_latency step %0d dut%0d: got irq=%0b id=%0d act=%h",
                                 k, d, obs_irq[d], obs_id[d], obs_act[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_priority();
        step_t seq[$];
        reset_dut();
        seq.push_back(mk(0, 8'h00, 1, 8'hFF, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h24, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h24, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h24, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h24, 0, 8'h00, 2'b11, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h24, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h24, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h24, 0, 8'h00, 2'b00, 2'b11, 4'd3));
        seq.push_back(mk(0, 8'h24, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        foreach (seq[k]) begin
            apply_stimulus(seq[k]);
            clock_edge();
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if ({obs_irq[d], obs_id[d], obs_pend[d], obs_act[d]} !== {m_irq[d], m_id[d], m_pend[d], m_act[d]}) begin
                    n_err++;
                    $display("[TB] FAIL priority step %0d dut%0d: got irq=%0b id=%0d pend=%h act=%h, expected irq=%0b id=%0d pend=%h act=%h",
                             k, d, obs_irq[d], obs_id[d], obs_pend[d], obs_act[d], m_irq[d], m_id[d], m_pend[d], m_act[d]);
                end
            end
            if (k == 3 || k == 4 || k == 6 || k == 7) begin
                n_vec++;
                if ((k == 3 && (obs_id[0] !== 4'd3 || obs_id[1] !== 4'd3)) ||
                    (k == 4 && (obs_irq[1] !== 1'b1 || obs_id[1] !== 4'd6 || obs_irq[0] !== 1'b0)) ||
                    (k == 6 && obs_irq[0] !== 1'b0) ||
                    (k == 7 && (obs_irq[0] !== 1'b1 || obs_id[0] !== 4'd6))) begin
                    n_err++;
                    $display("[TB] FAIL priority_ids step %0d: got dut0 irq=%0b id=%0d dut1 irq=%0b id=%0d",
                             k, obs_irq[0], obs_id[0], obs_irq[1], obs_id[1]);
                end
            end
        end
    endtask

    task automatic test_edge_claim();
        step_t seq[$];
        reset_dut();
        seq.push_back(mk(0, 8'h00, 1, 8'hFF, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h02, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h00, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h02, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h00, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h00, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h00, 0, 8'h00, 2'b11, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h00, 0, 8'h00, 2'b00, 2'b11, 4'd2));
        seq.push_back(mk(0, 8'h00, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        foreach (seq[k]) begin
            apply_stimulus(seq[k]);
            clock_edge();
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if ({obs_irq[d], obs_id[d], obs_pend[d], obs_act[d]} !== {m_irq[d], m_id[d], m_pend[d], m_act[d]}) begin
                    n_err++;
                    $display("[TB] FAIL edge_claim step %0d dut%0d: got irq=%0b id=%0d pend=%h act=%h, expected irq=%0b id=%0d pend=%h act=%h",
                             k, d, obs_irq[d], obs_id[d], obs_pend[d], obs_act[d], m_irq[d], m_id[d], m_pend[d], m_act[d]);
                end
                if (k == 4 || k == 6 || k == 7) begin
                    n_vec++;
                    if ((k == 4 && (obs_irq[d] !== 1'b1 || obs_id[d] !== 4'd2)) ||
                        (k == 6 && (obs_pend[d] !== 8'h02 || obs_act[d] !== 8'h02)) ||
                        (k == 7 && (obs_irq[d] !== 1'b1 || obs_id[d] !== 4'd2))) begin
                        n_err++;
                        $display("[TB] FAIL edge_retain step %0d dut%0d: got irq=%0b id=%0d pend=%h act=%h",
                                 k, d, obs_irq[d], obs_id[d], obs_pend[d], obs_act[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_enable_mask();
        step_t seq[$];
        reset_dut();
        seq.push_back(mk(0, 8'h01, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h01, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h01, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h01, 1, 8'h01, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h01, 0, 8'h00, 2'b11, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h01, 0, 8'h00, 2'b00, 2'b11, 4'd0));
        seq.push_back(mk(0, 8'h01, 0, 8'h00, 2'b00, 2'b11, 4'd9));
        seq.push_back(mk(0, 8'h01, 0, 8'h00, 2'b00, 2'b11, 4'd1));
        seq.push_back(mk(0, 8'h01, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        foreach (seq[k]) begin
            apply_stimulus(seq[k]);
            clock_edge();
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if ({obs_irq[d], obs_id[d], obs_pend[d], obs_act[d]} !== {m_irq[d], m_id[d], m_pend[d], m_act[d]}) begin
                    n_err++;
                    $display("[TB] FAIL enable_mask step %0d dut%0d: got irq=%0b id=%0d pend=%h act=%h, expected irq=%0b id=%0d pend=%h act=%h",
                             k, d, obs_irq[d], obs_id[d], obs_pend[d], obs_act[d], m_irq[d], m_id[d], m_pend[d], m_act[d]);
                end
                if (k == 2 || k == 3 || k == 6) begin
                    n_vec++;
                    if ((k == 2 && (obs_irq[d] !== 1'b0 || obs_pend[d] !== 8'h01)) ||
                        (k == 3 && (obs_irq[d] !== 1'b1 || obs_id[d] !== 4'd1)) ||
                        (k == 6 && (obs_act[d] !== 8'h01 || obs_irq[d] !== 1'b0))) begin
                        n_err++;
                        $display("[TB] FAIL enable_gate step %0d dut%0d: got irq=%0b id=%0d pend=%h act=%h",
                                 k, d, obs_irq[d], obs_id[d], obs_pend[d], obs_act[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        step_t seq[$];
        reset_dut();
        seq.push_back(mk(0, 8'h00, 1, 8'hFF, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h50, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h50, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h50, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h50, 0, 8'h00, 2'b11, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h50, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(1, 8'h50, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        seq.push_back(mk(0, 8'h00, 0, 8'h00, 2'b00, 2'b00, 4'd0));
        foreach (seq[k]) begin
            apply_stimulus(seq[k]);
            clock_edge();
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if ({obs_irq[d], obs_id[d], obs_pend[d], obs_act[d]} !== {m_irq[d], m_id[d], m_pend[d], m_act[d]}) begin
                    n_err++;
                    $display("[TB] FAIL reset_midop step %0d dut%0d: got irq=%0b id=%0d pend=%h act=%h, expected irq=%0b id=%0d pend=%h act=%h",
                             k, d, obs_irq[d], obs_id[d], obs_pend[d], obs_act[d], m_irq[d], m_id[d], m_pend[d], m_act[d]);
                end
                if (k == 5 || k == 6) begin
                    n_vec++;
                    if ((k == 5 && (obs_act[d] !== 8'h10 || obs_pend[d] !== 8'h40)) ||
                        (k == 6 && {obs_irq[d], obs_id[d], obs_pend[d], obs_act[d]} !== 21'd0)) begin
                        n_err++;
                        $display("[TB] FAIL reset_clear step %0d dut%0d: got irq=%0b id=%0d pend=%h act=%h",
                                 k, d, obs_irq[d], obs_id[d], obs_pend[d], obs_act[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        reset_dut();
        apply_stimulus(mk(0, 8'h00, 1, 8'hFF, 2'b00, 2'b00, 4'd0));
        clock_edge();
        for (int k = 0; k < 600; k++) begin
            rst_r     = ($urandom_range(0, 249) == 0);
            src_r     = src_r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            en_we_r   = ($urandom_range(0, 15) == 0);
            en_data_r = 8'($urandom) | 8'($urandom);
            for (int d = 0; d < 2; d++) begin
                claim_r[d]    = ($urandom_range(0, 2) == 0);
                complete_r[d] = ($urandom_range(0, 2) == 0);
                cid_r[d]      = 4'($urandom_range(0, 9));
            end
            clock_edge();
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if ({obs_irq[d], obs_id[d], obs_pend[d], obs_act[d]} !== {m_irq[d], m_id[d], m_pend[d], m_act[d]}) begin
                    n_err++;
                    $display("[TB] FAIL random cycle %0d dut%0d: got irq=%0b id=%0d pend=%h act=%h, expected irq=%0b id=%0d pend=%h act=%h",
                             k, d, obs_irq[d], obs_id[d], obs_pend[d], obs_act[d], m_irq[d], m_id[d], m_pend[d], m_act[d]);
                end
            end
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_r      = 1'b1;
        src_r      = '0;
        en_we_r    = 1'b0;
        en_data_r  = '0;
        claim_r    = '0;
        complete_r = '0;
        cid_r[0]   = '0;
        cid_r[1]   = '0;
        test_reset();
        test_level_claim();
        test_priority();
        test_edge_claim();
        test_enable_mask();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
